// File: rtl/regfile_reader_pkg.sv
// Shared defaults and FSM encoding for the register-file read-out engine.
// The default sizes match the register-file instance this block drains.
package regfile_reader_pkg;

  localparam int DEF_DATA_BIT = 48;
  localparam int DEF_REG_NUM  = 16;
  localparam int DEF_ADDR_NUM = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/regfile_reader_max.sv
// Running unsigned maximum of the accepted output beats.
// Cleared on an accepted start and updated on every handshake.
module regfile_reader_max
  import regfile_reader_pkg::*;
#(
  parameter int DATA_BIT = DEF_DATA_BIT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                upd,
  input  logic [DATA_BIT-1:0] data,
  output logic [DATA_BIT-1:0] max_val
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_val <= '0;
    end else if (clr) begin
      max_val <= '0;
    end else if (upd && (data > max_val)) begin
      max_val <= data;
    end
  end

endmodule

// File: rtl/regfile_reader.sv
// Sequential read-out engine: walks entries 0..len-1 and streams them on valid/ready.
// Optional running maximum on o_max is built only when READER_MAX_EN is defined.
//
// state | meaning
// IDLE  | waiting for i_start, outputs quiet
// FETCH | reading entry 0 into the output register
// SEND  | beat presented; prefetches entry ptr on each handshake
// DONE  | one-cycle o_done pulse
module regfile_reader
  import regfile_reader_pkg::*;
#(
  parameter int DATA_BIT = DEF_DATA_BIT,
  parameter int REG_NUM  = DEF_REG_NUM,
  parameter int ADDR_NUM = DEF_ADDR_NUM
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [ADDR_NUM:0]   i_count,
  output logic                o_busy,
  output logic [ADDR_NUM-1:0] o_rd_addr,
  input  logic [DATA_BIT-1:0] i_rd_data,
  output logic                o_valid,
  output logic [DATA_BIT-1:0] o_data,
  output logic                o_last,
  input  logic                i_ready,
  output logic                o_done,
  output logic [DATA_BIT-1:0] o_max
);

  localparam logic [ADDR_NUM:0] REG_NUM_C = (ADDR_NUM + 1)'(REG_NUM);
  localparam logic [ADDR_NUM:0] CNT_ONE   = (ADDR_NUM + 1)'(1);

  rd_state_e           state, state_nxt;
  logic [ADDR_NUM:0]   ptr, ptr_nxt;
  logic [ADDR_NUM:0]   idx, idx_nxt;
  logic [ADDR_NUM:0]   len, len_nxt;
  logic [ADDR_NUM:0]   len_clamp;
  logic [DATA_BIT-1:0] data_nxt;
  logic                valid_nxt;
  logic                last_nxt;
  logic                hshake;

  assign hshake    = o_valid & i_ready;
  assign len_clamp = (i_count > REG_NUM_C) ? REG_NUM_C : i_count;
  assign o_busy    = (state != IDLE);
  assign o_done    = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      idx     <= '0;
      len     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      idx     <= idx_nxt;
      len     <= len_nxt;
      o_data  <= data_nxt;
      o_valid <= valid_nxt;
      o_last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx;
    len_nxt   = len;
    data_nxt  = o_data;
    valid_nxt = o_valid;
    last_nxt  = o_last;
    o_rd_addr = '0;
    case (state)
      IDLE: begin
        if (i_start) begin
          len_nxt   = len_clamp;
          ptr_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = (len_clamp == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        data_nxt  = i_rd_data;
        valid_nxt = 1'b1;
        ptr_nxt   = CNT_ONE;
        last_nxt  = (len == CNT_ONE);
        state_nxt = SEND;
      end
      SEND: begin
        // ptr == REG_NUM only while the final beat is held; no read is issued then
        if (ptr < REG_NUM_C) o_rd_addr = ptr[ADDR_NUM-1:0];
        if (hshake) begin
          if (o_last) begin
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            state_nxt = DONE;
          end else begin
            data_nxt = i_rd_data;
            ptr_nxt  = ptr + CNT_ONE;
            idx_nxt  = idx + CNT_ONE;
            last_nxt = ((idx + CNT_ONE) == (len - CNT_ONE));
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef READER_MAX_EN
  logic start_acc;
  assign start_acc = (state == IDLE) & i_start;

  regfile_reader_max #(
    .DATA_BIT (DATA_BIT)
  ) u_max (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start_acc),
    .upd     (hshake),
    .data    (o_data),
    .max_val (o_max)
  );
`else
  assign o_max = '0;
`endif

endmodule

// File: tb/tb_regfile_reader.sv
// Self-checking bench for regfile_reader: directed and random scans against a queue model.
module tb_regfile_reader;

  localparam int DW = 48;
  localparam int RN = 16;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          i_start;
  logic [AW:0]   i_count;
  logic          o_busy;
  logic [AW-1:0] o_rd_addr;
  logic [DW-1:0] i_rd_data;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic          i_ready;
  logic          o_done;
  logic [DW-1:0] o_max;

  logic [DW-1:0] mem [RN];
  int checks = 0;
  int fails  = 0;

  assign i_rd_data = mem[o_rd_addr];

  regfile_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .i_count   (i_count),
    .o_busy    (o_busy),
    .o_rd_addr (o_rd_addr),
    .i_rd_data (i_rd_data),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_last    (o_last),
    .i_ready   (i_ready),
    .o_done    (o_done),
    .o_max     (o_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready always high, 1: pattern 1,0,0 repeating, 2: random
  task automatic run_scan(input int cnt, input int mode, input string name);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_max;
    logic [DW-1:0] held_data;
    logic          held_last;
    logic          prev_stall;
    int len, n, got, stalls, r;
    bit done_seen;
    len = (cnt > RN) ? RN : cnt;
    exp_q = {};
    exp_max = '0;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(mem[i]);
      if (mem[i] > exp_max) exp_max = mem[i];
    end
`ifndef READER_MAX_EN
    exp_max = '0;
`endif
    @(negedge clk);
    i_start = 1'b1;
    i_count = (AW + 1)'(cnt);
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    if (len > 0) begin
      check({name, "_fetch_busy"}, 64'(o_busy), 64'd1);
      check({name, "_fetch_valid"}, 64'(o_valid), 64'd0);
    end
    n = 0; got = 0; stalls = 0; r = 0; prev_stall = 1'b0; done_seen = 1'b0;
    held_data = '0; held_last = 1'b0;
    while (!done_seen && n < 400) begin
      if (o_done) begin
        done_seen = 1'b1;
        i_start = 1'b0;
      end else begin
        if (prev_stall) begin
          check({name, "_stall_valid"}, 64'(o_valid), 64'd1);
          check({name, "_stall_data"}, 64'(o_data), 64'(held_data));
          check({name, "_stall_last"}, 64'(o_last), 64'(held_last));
        end
        prev_stall = 1'b0;
        if (mode == 2) i_start = 1'($urandom_range(0, 1));
        if (o_valid) begin
          case (mode)
            0: i_ready = 1'b1;
            1: i_ready = ((r % 3) == 0);
            default: i_ready = 1'($urandom_range(0, 1));
          endcase
          r++;
          if (i_ready) begin
            if (got < len) begin
              check({name, "_beat_data"}, 64'(o_data), 64'(exp_q[got]));
              check({name, "_beat_last"}, 64'(o_last), 64'(got == len - 1));
            end else begin
              check({name, "_extra_beat"}, 64'(got), 64'(len - 1));
            end
            got++;
          end else begin
            stalls++;
            prev_stall = 1'b1;
            held_data = o_data;
            held_last = o_last;
          end
        end else begin
          i_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        @(negedge clk);
        n++;
      end
    end
    check({name, "_done_seen"}, 64'(done_seen), 64'd1);
    check({name, "_done_time"}, 64'(n), 64'((len == 0) ? 0 : 1 + len + stalls));
    check({name, "_beats"}, 64'(got), 64'(len));
    check({name, "_done_valid"}, 64'(o_valid), 64'd0);
    check({name, "_done_max"}, 64'(o_max), 64'(exp_max));
    @(negedge clk);
    check({name, "_post_done"}, 64'(o_done), 64'd0);
    check({name, "_post_busy"}, 64'(o_busy), 64'd0);
    check({name, "_post_addr"}, 64'(o_rd_addr), 64'd0);
    check({name, "_post_max"}, 64'(o_max), 64'(exp_max));
  endtask

  initial begin
    logic [63:0] rnd;
    bit saw_done;
    rst_n = 1'b0;
    i_start = 1'b0;
    i_count = '0;
    i_ready = 1'b0;
    for (int i = 0; i < RN; i++) mem[i] = DW'(i * 3);
    #3;
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_last", 64'(o_last), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_addr", 64'(o_rd_addr), 64'd0);
    check("rst_max", 64'(o_max), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_scan(5, 0, "five");
    run_scan(0, 0, "zero");
    run_scan(4, 1, "stall4");
    run_scan(31, 0, "clamp");

    // reset mid-scan after the second handshake
    @(negedge clk);
    i_ready = 1'b1;
    i_start = 1'b1;
    i_count = 5'd8;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_pre_data", 64'(o_data), 64'd6);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(o_busy), 64'd0);
    check("abort_valid", 64'(o_valid), 64'd0);
    check("abort_data", 64'(o_data), 64'd0);
    check("abort_last", 64'(o_last), 64'd0);
    check("abort_addr", 64'(o_rd_addr), 64'd0);
    check("abort_max", 64'(o_max), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (o_done) saw_done = 1'b1;
    end
    check("abort_no_done", 64'(saw_done), 64'd0);
    run_scan(2, 0, "after_abort");

    mem[0] = 48'd5;
    mem[1] = 48'hFFFF_0000_0001;
    mem[2] = 48'd7;
    run_scan(3, 0, "max3");

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < RN; i++) begin
        rnd = {$urandom(), $urandom()};
        mem[i] = rnd[DW-1:0];
      end
      run_scan(int'($urandom_range(0, 31)), int'($urandom_range(0, 2)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
